// File: rtl/datapath_pipelined_if.sv
// Bus between the pipelined LEGv8 datapath and its surroundings
// (controller, instruction memory, data memory).
//   slave  : the datapath side (takes control + memory read data, drives
//            instr_D, PC and the data-memory request)
//   master : the system side (controller / memories / testbench)
//   N      : datapath width
interface datapath_pipelined_if #(
  parameter int N = 64
);
  // controller -> datapath (ID-stage control for the instruction in instr_D)
  logic         reg2loc;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic         Branch;
  logic         memRead;
  logic         memWrite;
  logic         regWrite;
  logic         memtoReg;
  // memories -> datapath
  logic [31:0]  IM_readData;
  logic [N-1:0] DM_readData;
  // datapath -> controller / memories
  logic [31:0]  instr_D;
  logic [N-1:0] IM_addr;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;

  modport slave (
    input  reg2loc, AluSrc, AluControl, Branch, memRead, memWrite, regWrite,
           memtoReg, IM_readData, DM_readData,
    output instr_D, IM_addr, DM_addr, DM_writeData, DM_writeEnable, DM_readEnable
  );

  modport master (
    output reg2loc, AluSrc, AluControl, Branch, memRead, memWrite, regWrite,
           memtoReg, IM_readData, DM_readData,
    input  instr_D, IM_addr, DM_addr, DM_writeData, DM_writeEnable, DM_readEnable
  );
endinterface

// File: rtl/datapath_pipelined.sv
// Five-stage LEGv8 datapath (IF, ID, EX, MEM, WB) with IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. No forwarding and no hazard detection: software pads
// RAW distances below 3 with NOPs. Taken CBZ resolves in MEM; with
// FLUSH_ON_BRANCH the three younger instructions are squashed.
//   clk   : rising-edge clock
//   reset : synchronous, active low; clears PC and all pipeline registers
//   stall : holds PC and IF/ID, injects a bubble into ID/EX
//   bus   : controller / instruction memory / data memory signals
module datapath_pipelined #(
  parameter int N               = 64,
  parameter bit FLUSH_ON_BRANCH = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 stall,
  datapath_pipelined_if.slave bus
);

  typedef struct packed {
    logic       alu_src;
    logic [3:0] alu_ctl;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]  instr;
    logic [N-1:0] pc;
  } ifid_t;

  typedef struct packed {
    ctrl_t        ctrl;
    logic [N-1:0] pc;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [N-1:0] imm;
    logic [4:0]   rd;
  } idex_t;

  typedef struct packed {
    logic         branch;
    logic         mem_read;
    logic         mem_write;
    logic         reg_write;
    logic         mem_to_reg;
    logic         zero;
    logic [N-1:0] alu;
    logic [N-1:0] wdata;
    logic [N-1:0] pc_branch;
    logic [4:0]   rd;
  } exmem_t;

  typedef struct packed {
    logic         reg_write;
    logic         mem_to_reg;
    logic [N-1:0] rdata;
    logic [N-1:0] alu;
    logic [4:0]   rd;
  } memwb_t;

  logic [N-1:0] pc;
  ifid_t        ifid,  ifid_d;
  idex_t        idex,  idex_d;
  exmem_t       exmem, exmem_d;
  memwb_t       memwb, memwb_d;

  logic [N-1:0] rf [0:31];  // entry 31 is never written; XZR is muxed to 0
  logic [N-1:0] wb_data;
  logic         pcsrc;

  // ---------------- IF ----------------
  assign ifid_d.instr = bus.IM_readData;
  assign ifid_d.pc    = pc;

  // ---------------- ID ----------------
  logic [31:0]  instr;
  logic [4:0]   ra1, ra2;
  logic [N-1:0] rd1, rd2, imm;

  assign instr = ifid.instr;
  assign ra1   = instr[9:5];
  assign ra2   = bus.reg2loc ? instr[4:0] : instr[20:16];

  // WB writes at the same edge ID/EX captures, so bypass the write port
  // to make a distance-3 RAW see the new value.
  always_comb begin
    rd1 = rf[ra1];
    rd2 = rf[ra2];
    if (memwb.reg_write && memwb.rd == ra1) rd1 = wb_data;
    if (memwb.reg_write && memwb.rd == ra2) rd2 = wb_data;
    if (ra1 == 5'd31) rd1 = '0;
    if (ra2 == 5'd31) rd2 = '0;
  end

  // Immediate by format: B imm26, CB imm19, I imm12 (zero-ext), D imm9.
  always_comb begin
    imm = '0;
    if (instr[31:26] == 6'b000101)
      imm = {{(N-26){instr[25]}}, instr[25:0]};
    else if (instr[31:24] == 8'b10110100)
      imm = {{(N-19){instr[23]}}, instr[23:5]};
    else if (instr[31:22] == 10'b1001000100)
      imm = {{(N-12){1'b0}}, instr[21:10]};
    else if (instr[31:23] == 9'b111110000 && !instr[21])
      imm = {{(N-9){instr[20]}}, instr[20:12]};
  end

  always_comb begin
    idex_d                 = '0;
    idex_d.ctrl.alu_src    = bus.AluSrc;
    idex_d.ctrl.alu_ctl    = bus.AluControl;
    idex_d.ctrl.branch     = bus.Branch;
    idex_d.ctrl.mem_read   = bus.memRead;
    idex_d.ctrl.mem_write  = bus.memWrite;
    idex_d.ctrl.reg_write  = bus.regWrite;
    idex_d.ctrl.mem_to_reg = bus.memtoReg;
    idex_d.pc              = ifid.pc;
    idex_d.rd1             = rd1;
    idex_d.rd2             = rd2;
    idex_d.imm             = imm;
    idex_d.rd              = instr[4:0];
  end

  // ---------------- EX ----------------
  logic [N-1:0] alu_b, alu_y;

  assign alu_b = idex.ctrl.alu_src ? idex.imm : idex.rd2;

  always_comb begin
    case (idex.ctrl.alu_ctl)
      4'b0000: alu_y = idex.rd1 & alu_b;
      4'b0001: alu_y = idex.rd1 | alu_b;
      4'b0010: alu_y = idex.rd1 + alu_b;
      4'b0110: alu_y = idex.rd1 - alu_b;
      4'b0111: alu_y = alu_b;
      4'b1100: alu_y = ~(idex.rd1 | alu_b);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.branch     = idex.ctrl.branch;
    exmem_d.mem_read   = idex.ctrl.mem_read;
    exmem_d.mem_write  = idex.ctrl.mem_write;
    exmem_d.reg_write  = idex.ctrl.reg_write;
    exmem_d.mem_to_reg = idex.ctrl.mem_to_reg;
    exmem_d.zero       = (alu_y == '0);
    exmem_d.alu        = alu_y;
    exmem_d.wdata      = idex.rd2;
    exmem_d.pc_branch  = idex.pc + (idex.imm << 2);
    exmem_d.rd         = idex.rd;
  end

  // ---------------- MEM ----------------
  assign pcsrc = exmem.branch & exmem.zero;

  always_comb begin
    memwb_d            = '0;
    memwb_d.reg_write  = exmem.reg_write;
    memwb_d.mem_to_reg = exmem.mem_to_reg;
    memwb_d.rdata      = bus.DM_readData;
    memwb_d.alu        = exmem.alu;
    memwb_d.rd         = exmem.rd;
  end

  // Enables are gated by reset so a store sitting in MEM during a reset
  // cycle never reaches memory.
  assign bus.instr_D        = ifid.instr;
  assign bus.IM_addr        = pc;
  assign bus.DM_addr        = exmem.alu;
  assign bus.DM_writeData   = exmem.wdata;
  assign bus.DM_writeEnable = exmem.mem_write & reset;
  assign bus.DM_readEnable  = exmem.mem_read & reset;

  // ---------------- WB ----------------
  assign wb_data = memwb.mem_to_reg ? memwb.rdata : memwb.alu;

  always_ff @(posedge clk) begin
    if (reset && memwb.reg_write && memwb.rd != 5'd31)
      rf[memwb.rd] <= wb_data;
  end

  // ---------------- pipeline registers ----------------
  // Priority: reset > taken branch > stall. MEM/WB always advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= '0;
      ifid  <= '0;
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      memwb <= memwb_d;
      if (pcsrc) begin
        pc <= exmem.pc_branch;
        if (FLUSH_ON_BRANCH) begin
          ifid  <= '0;
          idex  <= '0;
          exmem <= '0;
        end else begin
          ifid  <= ifid_d;
          idex  <= idex_d;
          exmem <= exmem_d;
        end
      end else begin
        exmem <= exmem_d;
        if (stall) begin
          idex <= '0;
        end else begin
          pc   <= pc + N'(4);
          ifid <= ifid_d;
          idex <= idex_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipelined.sv
`timescale 1ns/1ps
module tb_datapath_pipelined;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  // b0/dut0 squashes on branch, b1/dut1 runs delay slots; both share imem.
  datapath_pipelined_if #(.N(N)) b0 ();
  datapath_pipelined_if #(.N(N)) b1 ();

  datapath_pipelined #(.N(N), .FLUSH_ON_BRANCH(1'b1)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .bus(b0));
  datapath_pipelined #(.N(N), .FLUSH_ON_BRANCH(1'b0)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .bus(b1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  function automatic logic [31:0] rop(input logic [10:0] op, input logic [4:0] rd, rn, rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, rn, input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction
  function automatic logic [31:0] dt(input logic [10:0] op, input logic [4:0] rt, rn, input logic [8:0] imm);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] cbz(input logic [4:0] rt, input logic [18:0] imm);
    return {8'b10110100, imm, rt};
  endfunction

  // Controller: {reg2loc, AluSrc, AluControl, Branch, memRead, memWrite, regWrite, memtoReg}
  function automatic logic [10:0] dec(input logic [31:0] i);
    case (i[31:21])
      OP_ADD:  return {1'b0, 1'b0, 4'b0010, 5'b00010};
      OP_SUB:  return {1'b0, 1'b0, 4'b0110, 5'b00010};
      OP_AND:  return {1'b0, 1'b0, 4'b0000, 5'b00010};
      OP_ORR:  return {1'b0, 1'b0, 4'b0001, 5'b00010};
      OP_LDUR: return {1'b0, 1'b1, 4'b0010, 5'b01011};
      OP_STUR: return {1'b1, 1'b1, 4'b0010, 5'b00100};
      default: begin
        if (i[31:22] == 10'b1001000100) return {1'b0, 1'b1, 4'b0010, 5'b00010};
        if (i[31:24] == 8'b10110100)    return {1'b1, 1'b0, 4'b0111, 5'b10000};
        return '0;
      end
    endcase
  endfunction

  assign {b0.reg2loc, b0.AluSrc, b0.AluControl, b0.Branch, b0.memRead, b0.memWrite,
          b0.regWrite, b0.memtoReg} = dec(b0.instr_D);
  assign {b1.reg2loc, b1.AluSrc, b1.AluControl, b1.Branch, b1.memRead, b1.memWrite,
          b1.regWrite, b1.memtoReg} = dec(b1.instr_D);

  // ---------------- memories ----------------
  logic [31:0]  imem [0:63];
  logic [N-1:0] dm0  [0:15];
  logic [N-1:0] dm1  [0:15];

  assign b0.IM_readData = (b0.IM_addr < N'(256)) ? imem[b0.IM_addr[7:2]] : 32'h0;
  assign b1.IM_readData = (b1.IM_addr < N'(256)) ? imem[b1.IM_addr[7:2]] : 32'h0;
  assign b0.DM_readData = dm0[b0.DM_addr[6:3]];
  assign b1.DM_readData = dm1[b1.DM_addr[6:3]];

  always @(posedge clk) begin
    if (b0.DM_writeEnable) dm0[b0.DM_addr[6:3]] <= b0.DM_writeData;
    if (b1.DM_writeEnable) dm1[b1.DM_addr[6:3]] <= b1.DM_writeData;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [N-1:0] addr;
    logic [N-1:0] data;
  } wr_t;
  wr_t q0[$];
  wr_t q1[$];

  function automatic wr_t wr(input logic [N-1:0] a, input logic [N-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (b0.DM_writeEnable) begin
      chk("dut0_wr_expected", N'(q0.size() > 0), N'(1));
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("dut0_wr_addr", b0.DM_addr, e.addr);
        chk("dut0_wr_data", b0.DM_writeData, e.data);
      end
    end
    if (b1.DM_writeEnable) begin
      chk("dut1_wr_expected", N'(q1.size() > 0), N'(1));
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1_wr_addr", b1.DM_addr, e.addr);
        chk("dut1_wr_data", b1.DM_writeData, e.data);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clr_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic push_both(input logic [N-1:0] a, input logic [N-1:0] d);
    q0.push_back(wr(a, d));
    q1.push_back(wr(a, d));
  endtask

  // Holds reset for two edges, checks the cleared outputs, then releases.
  // On return we sit at the negedge of cycle 0 (IM_addr == 0).
  task automatic do_reset(input string tag);
    reset = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pc0"},    b0.IM_addr, '0);
    chk({tag, "_pc1"},    b1.IM_addr, '0);
    chk({tag, "_instr0"}, N'(b0.instr_D), '0);
    chk({tag, "_we0"},    N'(b0.DM_writeEnable), '0);
    chk({tag, "_re0"},    N'(b0.DM_readEnable), '0);
    chk({tag, "_addr0"},  b0.DM_addr, '0);
    chk({tag, "_wd1"},    b1.DM_writeData, '0);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dm0[i] = '0;
      dm1[i] = '0;
    end

    // ---- 1: fetch sequence, arithmetic, load/store, XZR ----
    clr_imem();
    imem[0]  = addi(5'd1, 5'd31, 12'd5);
    imem[4]  = rop(OP_ADD, 5'd2, 5'd1, 5'd1);
    imem[8]  = dt(OP_STUR, 5'd2, 5'd31, 9'd8);
    imem[9]  = dt(OP_LDUR, 5'd3, 5'd31, 9'd8);
    imem[12] = dt(OP_STUR, 5'd3, 5'd31, 9'd16);   // distance 3: needs RF bypass
    imem[13] = addi(5'd31, 5'd31, 12'd7);
    imem[17] = dt(OP_STUR, 5'd31, 5'd31, 9'd24);
    imem[18] = rop(OP_SUB, 5'd4, 5'd1, 5'd2);
    imem[19] = rop(OP_ORR, 5'd5, 5'd1, 5'd2);
    imem[20] = rop(OP_AND, 5'd6, 5'd2, 5'd3);
    imem[21] = dt(OP_STUR, 5'd4, 5'd31, 9'd32);
    imem[22] = dt(OP_STUR, 5'd5, 5'd31, 9'd40);
    imem[23] = dt(OP_STUR, 5'd6, 5'd31, 9'd48);
    imem[24] = dt(OP_STUR, 5'd2, 5'd1, 9'h1FB);   // [X1,#-5] -> address 0
    push_both(64'd8,  64'd10);
    push_both(64'd16, 64'd10);
    push_both(64'd24, 64'd0);
    push_both(64'd32, -64'sd5);
    push_both(64'd40, 64'd15);
    push_both(64'd48, 64'd10);
    push_both(64'd0,  64'd10);
    do_reset("rst1");
    for (int k = 0; k < 40; k++) begin
      if (k < 4) begin
        chk("fetch_seq0", b0.IM_addr, N'(4 * k));
        chk("fetch_seq1", b1.IM_addr, N'(4 * k));
      end
      if (k == 12) begin
        chk("ldur_re",   N'(b0.DM_readEnable), N'(1));
        chk("ldur_addr", b0.DM_addr, N'(8));
      end
      @(negedge clk);
    end
    chk("t1_q0_left", N'(q0.size()), '0);
    chk("t1_q1_left", N'(q1.size()), '0);

    // ---- 2: taken CBZ, squash vs. delay slots ----
    clr_imem();
    imem[0]  = addi(5'd10, 5'd31, 12'd1);
    imem[1]  = addi(5'd12, 5'd31, 12'd7);
    imem[4]  = cbz(5'd31, 19'd4);                // PC 0x10 -> 0x20
    imem[5]  = dt(OP_STUR, 5'd10, 5'd31, 9'd8);
    imem[6]  = addi(5'd12, 5'd31, 12'd3);
    imem[7]  = dt(OP_STUR, 5'd10, 5'd31, 9'd16);
    imem[11] = dt(OP_STUR, 5'd12, 5'd31, 9'd24);
    q0.push_back(wr(64'd24, 64'd7));
    q1.push_back(wr(64'd8,  64'd1));
    q1.push_back(wr(64'd16, 64'd1));
    q1.push_back(wr(64'd24, 64'd3));
    do_reset("rst2");
    for (int k = 0; k < 30; k++) begin
      if (k == 7) begin
        chk("br_pre0", b0.IM_addr, N'(32'h1C));
        chk("br_pre1", b1.IM_addr, N'(32'h1C));
      end
      if (k == 8) begin
        chk("br_tgt0",   b0.IM_addr, N'(32'h20));
        chk("br_tgt1",   b1.IM_addr, N'(32'h20));
        chk("br_flush0", N'(b0.instr_D), '0);
        chk("br_keep1",  N'(b1.instr_D), N'(imem[7]));
      end
      @(negedge clk);
    end
    chk("t2_q0_left", N'(q0.size()), '0);
    chk("t2_q1_left", N'(q1.size()), '0);

    // ---- 3: three-cycle stall ----
    clr_imem();
    imem[0]  = addi(5'd13, 5'd31, 12'd21);
    imem[1]  = addi(5'd14, 5'd31, 12'd22);
    imem[2]  = addi(5'd15, 5'd31, 12'd23);
    imem[6]  = rop(OP_ADD, 5'd16, 5'd13, 5'd14);
    imem[7]  = dt(OP_STUR, 5'd15, 5'd31, 9'd8);
    imem[10] = dt(OP_STUR, 5'd16, 5'd31, 9'd16);
    push_both(64'd8,  64'd23);
    push_both(64'd16, 64'd43);
    do_reset("rst3");
    for (int k = 0; k < 36; k++) begin
      if (k >= 4 && k <= 6) begin
        chk("stall_pc0", b0.IM_addr, N'(12));
        chk("stall_pc1", b1.IM_addr, N'(12));
      end
      if (k >= 3 && k <= 6) chk("stall_instr", N'(b0.instr_D), N'(imem[2]));
      if (k == 7) chk("stall_resume", b0.IM_addr, N'(16));
      stall = (k >= 3 && k <= 5);
      @(negedge clk);
    end
    stall = 1'b0;
    chk("t3_q0_left", N'(q0.size()), '0);
    chk("t3_q1_left", N'(q1.size()), '0);

    // ---- 4: reset while a store is in EX ----
    clr_imem();
    imem[0] = dt(OP_STUR, 5'd10, 5'd31, 9'd8);
    do_reset("rst4");
    repeat (2) @(negedge clk);    // cycle 2: STUR in EX
    reset = 1'b0;
    clr_imem();                   // after release only NOPs are fetched
    @(negedge clk);
    chk("midrst_we0",    N'(b0.DM_writeEnable), '0);
    chk("midrst_we1",    N'(b1.DM_writeEnable), '0);
    chk("midrst_pc0",    b0.IM_addr, '0);
    chk("midrst_instr0", N'(b0.instr_D), '0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_q0_left", N'(q0.size()), '0);
    chk("t4_q1_left", N'(q1.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
